// File: rtl/apb_pkg.sv
// Shared definitions for the APB memory completer: FSM states, default bus
// widths and the wait-counter width.
package apb_pkg;

  localparam int unsigned APB_DATA_W = 8;
  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_slave_storage.sv
// Register file behind the APB completer: DEPTH words plus a per-word "written"
// flag. Data words are not reset; only the valid flags are.
module apb_slave_storage #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned IDX_W      = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[waddr_i] <= 1'b1;
    end
  end

  assign rdata_o  = mem_q[raddr_i];
  assign rvalid_o = valid_q[raddr_i];

endmodule

// File: rtl/apb_mem_slave.sv
// APB completer serving bridge accesses from an internal register file, with
// programmable wait states, PSLVERR on bad/unwritten addresses and a
// one-cycle proto_err pulse on bus sequencing violations.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = APB_DATA_W,
  parameter int unsigned ADDR_WIDTH  = APB_ADDR_W,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  proto_err,
  output logic [1:0]            dbg_state_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: a transfer completes in the single cycle where PSEL, PENABLE
  // and PREADY are all high; PRDATA and PSLVERR are meaningful only then.
  apb_state_e              state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wr_q, wr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    perr_q, perr_d;

  logic                    complete;
  logic                    in_range;
  logic                    err;
  logic                    mem_we;
  logic [IDX_W-1:0]        idx;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_rvalid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    perr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PENABLE) begin
          perr_d = 1'b1;
        end else if (PSEL) begin
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        addr_d  = PADDR;
        wr_d    = PWRITE;
        wdata_d = PWDATA;
        cnt_d   = WAIT_CNT_W'(WAIT_STATES);
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
          perr_d  = 1'b1;
        end else if (!PENABLE) begin
          // Master restarted mid-transfer: this cycle is the new setup phase.
          state_d = ST_SETUP;
          perr_d  = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      perr_q  <= perr_d;
    end
  end

  assign idx      = addr_q[IDX_W-1:0];
  assign in_range = (32'(addr_q) < DEPTH);
  assign complete = (state_q == ST_ACCESS) && (cnt_q == '0) && PSEL && PENABLE;
  assign err      = !in_range || (!wr_q && !mem_rvalid);
  assign mem_we   = complete && wr_q && !err;

  assign PREADY      = complete;
  assign PSLVERR     = complete && err;
  assign PRDATA      = (complete && !wr_q && !err) ? mem_rdata : '0;
  assign proto_err   = perr_q;
  assign dbg_state_o = state_q;

  apb_slave_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_storage (
    .clk_i    (PCLK),
    .rst_ni   (PRESETn),
    .we_i     (mem_we),
    .waddr_i  (idx),
    .wdata_i  (wdata_q),
    .raddr_i  (idx),
    .rdata_o  (mem_rdata),
    .rvalid_o (mem_rvalid)
  );

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: one instance with 2 wait states (index 0) and one
// with none (index 1), checked against an array model of the storage rules.
module tb_apb_mem_slave;
  import apb_pkg::*;

  localparam int DEPTH = 64;

  logic        clk;
  logic        rst_n;
  logic [1:0]  psel_v;
  logic [1:0]  penable_v;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [7:0]  pwdata;
  logic [7:0]  prdata_v [2];
  logic [1:0]  pready_v;
  logic [1:0]  pslverr_v;
  logic [1:0]  perr_v;
  logic [1:0]  dbg_v [2];

  int          tests_run = 0;
  int          fails = 0;
  int          wait_m [2] = '{2, 0};
  logic [7:0]  mem_m [2][DEPTH];
  bit          valid_m [2][DEPTH];
  logic [7:0]  exp_q [$];

  apb_mem_slave #(.DEPTH(DEPTH), .WAIT_STATES(2)) u_dut_w2 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel_v[0]), .PENABLE(penable_v[0]),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_v[0]),
    .PREADY(pready_v[0]), .PSLVERR(pslverr_v[0]), .proto_err(perr_v[0]),
    .dbg_state_o(dbg_v[0])
  );

  apb_mem_slave #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut_w0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel_v[1]), .PENABLE(penable_v[1]),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_v[1]),
    .PREADY(pready_v[1]), .PSLVERR(pslverr_v[1]), .proto_err(perr_v[1]),
    .dbg_state_o(dbg_v[1])
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", fails);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      psel_v    = '0;
      penable_v = '0;
      #4;
      check_eq("idle_rdy0", pready_v[0], 1'b0);
      check_eq("idle_rdy1", pready_v[1], 1'b0);
    end
  endtask

  // One full transfer: setup cycle, the completer's latch cycle, then
  // wait_m[d] wait cycles and one completing cycle. Control inputs are
  // scrambled during the access phase; they must have no effect.
  task automatic do_xfer(input int d, input bit wr, input logic [7:0] addr,
                         input logic [7:0] data, input bit restart);
    bit         err;
    logic [7:0] exp_rd;
    err = 1'b0;
    if (addr >= DEPTH) err = 1'b1;
    else if (!wr && !valid_m[d][addr[5:0]]) err = 1'b1;
    if (!wr) begin
      exp_rd = err ? 8'h00 : mem_m[d][addr[5:0]];
      exp_q.push_back(exp_rd);
    end
    @(negedge clk);
    psel_v    = '0;
    penable_v = '0;
    psel_v[d] = 1'b1;
    pwrite = wr;
    paddr  = addr;
    pwdata = data;
    #4;
    check_eq("setup_rdy", pready_v[d], 1'b0);
    @(negedge clk);
    penable_v[d] = 1'b1;
    #4;
    check_eq("latch_rdy", pready_v[d], 1'b0);
    check_eq("latch_perr", perr_v[d], restart);
    for (int k = 1; k <= wait_m[d] + 1; k++) begin
      @(negedge clk);
      paddr  = 8'($urandom);
      pwdata = 8'($urandom);
      pwrite = 1'($urandom);
      #4;
      check_eq("acc_perr", perr_v[d], 1'b0);
      if (k <= wait_m[d]) begin
        check_eq("wait_rdy", pready_v[d], 1'b0);
      end else begin
        check_eq("done_rdy", pready_v[d], 1'b1);
        check_eq("done_slverr", pslverr_v[d], err);
        if (!wr) check_eq("rd_data", prdata_v[d], exp_q.pop_front());
      end
    end
    if (wr && !err) begin
      mem_m[d][addr[5:0]]   = data;
      valid_m[d][addr[5:0]] = 1'b1;
    end
  endtask

  // Start a write on the 2-wait-state instance and disturb it in its first
  // wait cycle: kind 0 drops PSEL, kind 1 leaves it for a restart by the caller.
  task automatic start_and_disturb(input int kind, input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    psel_v = 2'b01; penable_v = 2'b00; pwrite = 1'b1; paddr = addr; pwdata = data;
    @(negedge clk);
    penable_v = 2'b01;
    @(negedge clk);
    if (kind == 0) begin
      psel_v = '0; penable_v = '0;
    end
    #4;
    check_eq("dist_rdy", pready_v[0], 1'b0);
    if (kind == 0) begin
      @(negedge clk); #4;
      check_eq("abort_perr", perr_v[0], 1'b1);
      check_eq("abort_rdy", pready_v[0], 1'b0);
      @(negedge clk); #4;
      check_eq("abort_perr_end", perr_v[0], 1'b0);
    end
  endtask

  task automatic clear_model_valid();
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < DEPTH; a++) valid_m[d][a] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; psel_v = '0; penable_v = '0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    clear_model_valid();
    repeat (3) @(negedge clk);
    #4;
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_rdy", pready_v[d], 1'b0);
      check_eq("rst_slverr", pslverr_v[d], 1'b0);
      check_eq("rst_rdata", prdata_v[d], 8'h00);
      check_eq("rst_perr", perr_v[d], 1'b0);
      check_eq("rst_state", dbg_v[d], ST_IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;

    do_xfer(0, 1'b1, 8'h05, 8'h0A, 1'b0);
    do_xfer(0, 1'b0, 8'h05, 8'h00, 1'b0);
    drive_idle(1);

    for (int i = 0; i < 8; i++) do_xfer(0, 1'b1, 8'(i), 8'(2 * i), 1'b0);
    for (int i = 0; i < 8; i++) do_xfer(0, 1'b0, 8'(i), 8'h00, 1'b0);
    drive_idle(2);

    do_xfer(0, 1'b0, 8'h2D, 8'h00, 1'b0);
    do_xfer(0, 1'b1, 8'h50, 8'h23, 1'b0);
    do_xfer(0, 1'b0, 8'h50, 8'h00, 1'b0);
    drive_idle(1);

    do_xfer(1, 1'b1, 8'h10, 8'h55, 1'b0);
    do_xfer(1, 1'b0, 8'h10, 8'h00, 1'b0);
    drive_idle(1);

    start_and_disturb(0, 8'h06, 8'hFF);
    do_xfer(0, 1'b0, 8'h06, 8'h00, 1'b0);
    drive_idle(1);

    // PENABLE without a prior setup while idle
    @(negedge clk);
    psel_v = '0; penable_v = 2'b11;
    @(negedge clk);
    penable_v = '0;
    #4;
    check_eq("idle_en_perr0", perr_v[0], 1'b1);
    check_eq("idle_en_perr1", perr_v[1], 1'b1);
    @(negedge clk); #4;
    check_eq("idle_en_end", perr_v[0], 1'b0);
    do_xfer(0, 1'b0, 8'h03, 8'h00, 1'b0);

    start_and_disturb(1, 8'h06, 8'h77);
    do_xfer(0, 1'b0, 8'h06, 8'h00, 1'b1);
    drive_idle(1);

    for (int n = 0; n < 60; n++) begin
      int         d;
      bit         wr;
      logic [7:0] a;
      d  = $urandom_range(0, 1);
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 23));
      do_xfer(d, wr, a, 8'($urandom), 1'b0);
      drive_idle($urandom_range(0, 2));
    end

    // Reset lands in the completing cycle of a write to 0x07
    @(negedge clk);
    psel_v = 2'b01; penable_v = 2'b00; pwrite = 1'b1; paddr = 8'h07; pwdata = 8'h99;
    @(negedge clk);
    penable_v = 2'b01;
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #4;
    check_eq("mid_rst_rdy", pready_v[0], 1'b0);
    check_eq("mid_rst_slverr", pslverr_v[0], 1'b0);
    check_eq("mid_rst_rdata", prdata_v[0], 8'h00);
    check_eq("mid_rst_perr", perr_v[0], 1'b0);
    check_eq("mid_rst_state", dbg_v[0], ST_IDLE);
    @(negedge clk);
    psel_v = '0; penable_v = '0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_model_valid();
    do_xfer(0, 1'b0, 8'h07, 8'h00, 1'b0);
    do_xfer(1, 1'b0, 8'h10, 8'h00, 1'b0);
    drive_idle(2);

    check_eq("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
